// File: rtl/lsu_mem_master.sv
// Load/store initiator in front of the data RAM: splits misaligned accesses into
// aligned word loads or byte stores, assembles load data and returns one response pulse.
module lsu_mem_master #(
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_load,
    output logic        mem_store,
    output logic [2:0]  mem_access,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, LD_LO, LD_HI, ST, RESP} state_t;

    state_t      state, state_nx;
    logic        store_q, err_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q, lo_q, hi_q;
    logic [1:0]  k_q;

    logic [2:0]  size_q;
    logic        mis_q, cross_q, accept;
    logic [31:0] shifted, ld_data;
    logic [7:0]  st_byte;

    function automatic logic [2:0] size_of(input logic [1:0] f);
        case (f)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_mis(input logic [2:0] f, input logic [1:0] off);
        return (f[1:0] == 2'b01 && off[0]) || (f[1:0] == 2'b10 && off != 2'b00);
    endfunction

    function automatic logic is_illegal(input logic st, input logic [2:0] f, input logic [1:0] off);
        return (f == 3'b011) || (f[2:1] == 2'b11) || (st && f[2]) ||
               (!MISALIGNED_EN && is_mis(f, off));
    endfunction

    assign accept     = req_valid && req_ready;
    assign size_q     = size_of(funct3_q[1:0]);
    assign mis_q      = is_mis(funct3_q, addr_q[1:0]);
    assign cross_q    = (4'(addr_q[1:0]) + 4'(size_q)) > 4'd4;
    assign shifted    = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});
    assign st_byte    = 8'(wdata_q >> {k_q, 3'b000});

    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP) && !rst;
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !store_q) ? ld_data : 32'h0;

    // Size truncation and sign/zero extension of the assembled load word
    always_comb begin
        ld_data = shifted;
        case (funct3_q)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_data = {24'h0, shifted[7:0]};
            3'b101:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Request capture, load data capture and misaligned-store byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q  <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            lo_q     <= 32'h0;
            hi_q     <= 32'h0;
            k_q      <= 2'd0;
        end else begin
            if (accept) begin
                store_q  <= req_store;
                err_q    <= is_illegal(req_store, req_funct3, req_addr[1:0]);
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                lo_q     <= 32'h0;
                hi_q     <= 32'h0;
                k_q      <= 2'd0;
            end
            if (state == LD_LO) lo_q <= mem_rdata;
            if (state == LD_HI) hi_q <= mem_rdata;
            if (state == ST)    k_q  <= k_q + 2'd1;
        end
    end

    always_comb begin
        state_nx   = state;
        mem_load   = 1'b0;
        mem_store  = 1'b0;
        mem_access = 3'b000;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (is_illegal(req_store, req_funct3, req_addr[1:0])) state_nx = RESP;
                    else if (req_store)                                  state_nx = ST;
                    else                                                 state_nx = LD_LO;
                end
            end
            LD_LO: begin
                mem_load   = 1'b1;
                mem_access = 3'b010;
                mem_addr   = {addr_q[31:2], 2'b00};
                state_nx   = cross_q ? LD_HI : RESP;
            end
            LD_HI: begin
                mem_load   = 1'b1;
                mem_access = 3'b010;
                mem_addr   = {addr_q[31:2], 2'b00} + 32'd4;
                state_nx   = RESP;
            end
            ST: begin
                mem_store = 1'b1;
                if (mis_q) begin
                    mem_access = 3'b000;
                    mem_addr   = addr_q + 32'(k_q);
                    mem_wdata  = {24'h0, st_byte};
                    if (k_q == 2'(size_q - 3'd1)) state_nx = RESP;
                end else begin
                    mem_access = funct3_q;
                    mem_addr   = addr_q;
                    mem_wdata  = wdata_q;
                    state_nx   = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // No RAM strobe may reach the memory during a reset cycle
        if (rst) begin
            mem_load   = 1'b0;
            mem_store  = 1'b0;
            mem_access = 3'b000;
            mem_addr   = 32'h0;
            mem_wdata  = 32'h0;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: a behavioural RAM, expected responses and RAM
// transactions queued by the stimulus, popped and compared by a negedge monitor.
module tb_lsu_mem_master;

    logic        clk, rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_load, mem_store;
    logic [2:0]  mem_access;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        req_valid2, req_ready2, req_store2;
    logic [2:0]  req_funct32;
    logic [31:0] req_addr2, req_wdata2;
    logic        resp_valid2, resp_err2;
    logic [31:0] resp_rdata2;
    logic        mem_load2, mem_store2;
    logic [2:0]  mem_access2;
    logic [31:0] mem_addr2, mem_wdata2, mem_rdata2;

    lsu_mem_master #(.MISALIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_load(mem_load), .mem_store(mem_store),
        .mem_access(mem_access), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    lsu_mem_master #(.MISALIGNED_EN(1'b0)) dut_noalign (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_store(req_store2), .req_funct3(req_funct32), .req_addr(req_addr2),
        .req_wdata(req_wdata2), .resp_valid(resp_valid2), .resp_rdata(resp_rdata2),
        .resp_err(resp_err2), .mem_load(mem_load2), .mem_store(mem_store2),
        .mem_access(mem_access2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] cyc;
    } resp_t;

    typedef struct packed {
        logic        ld;
        logic        st;
        logic [2:0]  acc;
        logic [31:0] addr;
        logic [31:0] wd;
    } op_t;

    resp_t exp_q[$];
    op_t   op_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    bit    preload = 1'b0;

    logic [31:0] ram [0:127];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: combinational read, byte/half/word write shifted by address
    assign mem_rdata  = ram[mem_addr[8:2]];
    assign mem_rdata2 = 32'h5A5A5A5A;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) ram[i] <= 32'h0;
            ram[64]  <= 32'h88776655;
            ram[65]  <= 32'h44332211;
            ram[127] <= 32'hA1B2C3D4;
            ram[0]   <= 32'hE5F60718;
        end else if (mem_store) begin
            case (mem_access)
                3'b000:  ram[mem_addr[8:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
                3'b001:  ram[mem_addr[8:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                default: ram[mem_addr[8:2]] <= mem_wdata;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_op(input logic ld, input logic st, input logic [2:0] acc,
                           input logic [31:0] addr, input logic [31:0] wd);
        op_q.push_back('{ld, st, acc, addr, wd});
    endtask

    // Issue one request; expected response lands lat cycles after the accept cycle
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input int lat, input bit hold);
        int w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout addr=%h", a);
            return;
        end
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        exp_q.push_back('{exp_rd, exp_err, 32'(cyc + lat)});
        @(negedge clk);
        if (hold) begin
            req_store  = 1'b0;
            req_funct3 = 3'b010;
            req_addr   = 32'h0;
            req_wdata  = 32'hFFFFFFFF;
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic monitor();
        resp_t e;
        op_t   o, a;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected rdata=%h err=%b cyc=%0d", resp_rdata, resp_err, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_rdata !== e.rdata || resp_err !== e.err || 32'(cyc) !== e.cyc) begin
                        failures++;
                        $display("FAIL resp actual rdata=%h err=%b cyc=%0d expected rdata=%h err=%b cyc=%0d",
                                 resp_rdata, resp_err, cyc, e.rdata, e.err, e.cyc);
                    end
                end
            end
            if (mem_load || mem_store) begin
                a = '{mem_load, mem_store, mem_access, mem_addr, mem_wdata};
                checks++;
                if (op_q.size() == 0) begin
                    failures++;
                    $display("FAIL mem_op_unexpected ld=%b st=%b acc=%b addr=%h wd=%h",
                             a.ld, a.st, a.acc, a.addr, a.wd);
                end else begin
                    o = op_q.pop_front();
                    if (a !== o) begin
                        failures++;
                        $display("FAIL mem_op actual ld=%b st=%b acc=%b addr=%h wd=%h expected ld=%b st=%b acc=%b addr=%h wd=%h",
                                 a.ld, a.st, a.acc, a.addr, a.wd, o.ld, o.st, o.acc, o.addr, o.wd);
                    end
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        preload    = 1'b1;
        req_valid  = 1'b0; req_store  = 1'b0; req_funct3  = 3'b000; req_addr  = 32'h0; req_wdata  = 32'h0;
        req_valid2 = 1'b0; req_store2 = 1'b0; req_funct32 = 3'b000; req_addr2 = 32'h0; req_wdata2 = 32'h0;
        fork
            monitor();
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("rst_req_ready", 32'(req_ready), 32'h0);
                chk("rst_resp_valid", 32'(resp_valid), 32'h0);
                chk("rst_resp_rdata", resp_rdata, 32'h0);
                chk("rst_resp_err", 32'(resp_err), 32'h0);
                chk("rst_mem_strobes", {30'h0, mem_load, mem_store}, 32'h0);
                rst     = 1'b0;
                preload = 1'b0;
                @(negedge clk);
                chk("post_rst_req_ready", 32'(req_ready), 32'h1);

                // Loads within one word and crossing into the next
                push_op(1, 0, 3'b010, 32'h100, 32'h0);
                issue(0, 3'b100, 32'h101, 32'h0, 32'h00000066, 0, 2, 0);
                push_op(1, 0, 3'b010, 32'h100, 32'h0);
                issue(0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF88, 0, 2, 0);
                push_op(1, 0, 3'b010, 32'h100, 32'h0);
                push_op(1, 0, 3'b010, 32'h104, 32'h0);
                issue(0, 3'b001, 32'h103, 32'h0, 32'h00001188, 0, 3, 0);
                push_op(1, 0, 3'b010, 32'h100, 32'h0);
                push_op(1, 0, 3'b010, 32'h104, 32'h0);
                issue(0, 3'b010, 32'h102, 32'h0, 32'h22118877, 0, 3, 0);

                // Misaligned word store with req_valid held into the busy period
                push_op(0, 1, 3'b000, 32'h101, 32'h000000EF);
                push_op(0, 1, 3'b000, 32'h102, 32'h000000BE);
                push_op(0, 1, 3'b000, 32'h103, 32'h000000AD);
                push_op(0, 1, 3'b000, 32'h104, 32'h000000DE);
                issue(1, 3'b010, 32'h101, 32'hDEADBEEF, 32'h0, 0, 5, 1);
                push_op(1, 0, 3'b010, 32'h100, 32'h0);
                issue(0, 3'b010, 32'h100, 32'h0, 32'hADBEEF55, 0, 2, 0);
                push_op(1, 0, 3'b010, 32'h104, 32'h0);
                issue(0, 3'b010, 32'h104, 32'h0, 32'h443322DE, 0, 2, 0);

                // Aligned half store is passed through unshifted
                push_op(0, 1, 3'b001, 32'h102, 32'hFFFF1234);
                issue(1, 3'b001, 32'h102, 32'hFFFF1234, 32'h0, 0, 2, 0);
                push_op(1, 0, 3'b010, 32'h100, 32'h0);
                issue(0, 3'b101, 32'h102, 32'h0, 32'h00001234, 0, 2, 0);
                push_op(1, 0, 3'b010, 32'h100, 32'h0);
                issue(0, 3'b001, 32'h101, 32'h0, 32'h000034EF, 0, 2, 0);

                // Illegal encodings respond after one cycle without touching the RAM
                issue(0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1, 0);
                issue(1, 3'b100, 32'h100, 32'h12345678, 32'h0, 1, 1, 0);

                // Crossing load at the top of the address space wraps to zero
                push_op(1, 0, 3'b010, 32'hFFFFFFFC, 32'h0);
                push_op(1, 0, 3'b010, 32'h00000000, 32'h0);
                issue(0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h0718A1B2, 0, 3, 0);

                // Misaligned half store crossing a word boundary
                push_op(0, 1, 3'b000, 32'h103, 32'h000000FE);
                push_op(0, 1, 3'b000, 32'h104, 32'h000000CA);
                issue(1, 3'b001, 32'h103, 32'h0000CAFE, 32'h0, 0, 3, 0);
                push_op(1, 0, 3'b010, 32'h100, 32'h0);
                issue(0, 3'b010, 32'h100, 32'h0, 32'hFE34EF55, 0, 2, 0);
                push_op(1, 0, 3'b010, 32'h104, 32'h0);
                issue(0, 3'b000, 32'h104, 32'h0, 32'hFFFFFFCA, 0, 2, 0);

                // Reset during the second half of a crossing load aborts it silently
                push_op(1, 0, 3'b010, 32'h100, 32'h0);
                @(negedge clk);
                for (int w = 0; w < 50 && !req_ready; w++) @(negedge clk);
                chk("abort_setup_ready", 32'(req_ready), 32'h1);
                req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h102;
                @(posedge clk);
                @(negedge clk);
                req_valid = 1'b0;
                @(posedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                chk("abort_mem_load", 32'(mem_load), 32'h0);
                chk("abort_req_ready", 32'(req_ready), 32'h0);
                chk("abort_resp_valid", 32'(resp_valid), 32'h0);
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("abort_ready_after", 32'(req_ready), 32'h1);
                repeat (4) @(negedge clk);

                // Instance with splitting disabled rejects misaligned, serves aligned
                req_valid2 = 1'b1; req_store2 = 1'b0; req_funct32 = 3'b010; req_addr2 = 32'h102;
                @(negedge clk);
                req_valid2 = 1'b0;
                chk("noalign_resp_valid", 32'(resp_valid2), 32'h1);
                chk("noalign_resp_err", 32'(resp_err2), 32'h1);
                chk("noalign_resp_rdata", resp_rdata2, 32'h0);
                chk("noalign_no_load", 32'(mem_load2), 32'h0);
                @(negedge clk);
                req_valid2 = 1'b1; req_addr2 = 32'h100;
                @(negedge clk);
                req_valid2 = 1'b0;
                chk("noalign_ld_strobe", 32'(mem_load2), 32'h1);
                chk("noalign_ld_addr", mem_addr2, 32'h100);
                @(negedge clk);
                chk("noalign_ok_valid", 32'(resp_valid2), 32'h1);
                chk("noalign_ok_err", 32'(resp_err2), 32'h0);
                chk("noalign_ok_rdata", resp_rdata2, 32'h5A5A5A5A);

                for (int w = 0; w < 200 && (exp_q.size() != 0 || op_q.size() != 0); w++)
                    @(negedge clk);
                while (exp_q.size() != 0) begin
                    resp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL resp_missing expected rdata=%h err=%b cyc=%0d", e.rdata, e.err, e.cyc);
                end
                while (op_q.size() != 0) begin
                    op_t o;
                    o = op_q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL mem_op_missing expected addr=%h wd=%h", o.addr, o.wd);
                end
            end
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
